// File: rtl/tick_timer_bank.sv
// tick_timer_bank: CLOCK_50 prescaler producing a one-cycle base tick, plus a
// bank of NCH independent countdown timers (one-shot or periodic) on that tick.

// One timer channel: IDLE/RUN state with count, reload and latched mode.
module tick_chan #(
  parameter int CW = 8
) (
  input  logic          CLOCK_50,
  input  logic          KEY,
  input  logic          tick,
  input  logic          stop,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          mode,
  input  logic          pause,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic          done
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state;
  logic [CW-1:0] reload;
  logic          mode_r;

  // stop beats load beats the tick decrement; done is a registered single-cycle pulse
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      mode_r <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state <= IDLE;
        count <= '0;
      end else if (load) begin
        if (load_val != '0) begin
          count  <= load_val;
          reload <= load_val;
          mode_r <= mode;
          state  <= RUN;
        end else begin
          // a zero load expires on the spot
          state <= IDLE;
          count <= '0;
          done  <= 1'b1;
        end
      end else if (state == RUN && tick && !pause) begin
        if (count > CW'(1)) begin
          count <= count - CW'(1);
        end else begin
          done <= 1'b1;
          if (mode_r) begin
            count <= reload;
          end else begin
            count <= '0;
            state <= IDLE;
          end
        end
      end
    end
  end

  assign busy = (state == RUN);
endmodule

module tick_timer_bank #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1,
  parameter int NCH     = 2,
  parameter int CW      = 8
) (
  input  logic              CLOCK_50,
  input  logic              KEY,
  input  logic              sync_clr,
  input  logic [NCH-1:0]    stop,
  input  logic [NCH-1:0]    load,
  input  logic [NCH*CW-1:0] load_val,
  input  logic [NCH-1:0]    mode,
  input  logic [NCH-1:0]    pause,
  output logic              base_tick,
  output logic [NCH*CW-1:0] count,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    done
);
  localparam int TICK_SAFE = (TICK_HZ > 0) ? TICK_HZ : 1;
  localparam int DIV       = CLK_HZ / TICK_SAFE;
  localparam int PW        = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  generate
    if (TICK_HZ < 1 || (CLK_HZ % TICK_SAFE) != 0 || DIV < 2) begin : g_bad_div
      $error("tick_timer_bank: CLK_HZ/TICK_HZ must be an integer >= 2");
    end
    if (NCH < 1 || NCH > 8) begin : g_bad_nch
      $error("tick_timer_bank: NCH must be 1..8");
    end
  endgenerate

  typedef struct packed {
    logic          stop;
    logic          load;
    logic [CW-1:0] val;
    logic          mode;
    logic          pause;
  } chan_req_t;

  typedef struct packed {
    logic [CW-1:0] count;
    logic          busy;
    logic          done;
  } chan_rsp_t;

  chan_req_t [NCH-1:0] req;
  chan_rsp_t [NCH-1:0] rsp;
  logic [PW-1:0]       pre;

  // free-running 0..DIV-1 divider; tick is registered off the terminal count,
  // sync_clr restarts the phase and swallows a tick that was about to issue
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      pre       <= '0;
      base_tick <= 1'b0;
    end else if (sync_clr) begin
      pre       <= '0;
      base_tick <= 1'b0;
    end else begin
      pre       <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
      base_tick <= (pre == PRE_LAST);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign req[i] = '{stop:  stop[i],
                      load:  load[i],
                      val:   load_val[i*CW +: CW],
                      mode:  mode[i],
                      pause: pause[i]};

    tick_chan #(.CW(CW)) u_ch (
      .CLOCK_50 (CLOCK_50),
      .KEY      (KEY),
      .tick     (base_tick),
      .stop     (req[i].stop),
      .load     (req[i].load),
      .load_val (req[i].val),
      .mode     (req[i].mode),
      .pause    (req[i].pause),
      .count    (rsp[i].count),
      .busy     (rsp[i].busy),
      .done     (rsp[i].done)
    );

    assign count[i*CW +: CW] = rsp[i].count;
    assign busy[i]           = rsp[i].busy;
    assign done[i]           = rsp[i].done;
  end
endmodule

// File: tb/tb_tick_timer_bank.sv
// tb_tick_timer_bank: directed and random stimulus; a timestamped reference
// model queues expected done events, a negedge monitor compares every cycle.
module tb_tick_timer_bank;
  localparam int CLK_HZ = 10, TICK_HZ = 1, NCH = 2, CW = 8;
  localparam int DIV = CLK_HZ / TICK_HZ;

  logic              CLOCK_50 = 1'b0;
  logic              KEY      = 1'b0;
  logic              sync_clr = 1'b0;
  logic [NCH-1:0]    stop     = '0;
  logic [NCH-1:0]    load     = '0;
  logic [NCH-1:0]    mode     = '0;
  logic [NCH-1:0]    pause    = '0;
  logic [NCH*CW-1:0] load_val = '0;
  logic              base_tick;
  logic [NCH*CW-1:0] count;
  logic [NCH-1:0]    busy, done;

  int n_cmp = 0, n_err = 0, cyc = 0;

  tick_timer_bank #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NCH(NCH), .CW(CW)) u_dut (
    .CLOCK_50 (CLOCK_50), .KEY (KEY), .sync_clr (sync_clr), .stop (stop),
    .load (load), .load_val (load_val), .mode (mode), .pause (pause),
    .base_tick (base_tick), .count (count), .busy (busy), .done (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // ---------------- reference model ----------------
  // Time is the edge index e since reset release; ticks are timestamps
  // spaced DIV apart, re-anchored by sync_clr. Expiries become queued events.
  typedef struct { int ch; int e; int cnt; } ev_t;
  ev_t evq[$];
  int  e, tick_at;
  bit  tick_now;
  int  rem[NCH], rel[NCH];
  bit  run[NCH], per[NCH];

  task automatic model_reset();
    e = 0; tick_at = DIV; tick_now = 0;
    for (int c = 0; c < NCH; c++) begin run[c] = 0; per[c] = 0; rem[c] = 0; rel[c] = 0; end
    evq.delete();
  endtask

  task automatic model_step();
    bit t_seen;
    int v;
    t_seen = tick_now;           // tick visible to the channels before this edge
    e++;
    if (sync_clr) begin
      tick_now = 0;
      tick_at  = e + DIV;
    end else begin
      tick_now = (e == tick_at);
      if (tick_now) tick_at += DIV;
    end
    for (int c = 0; c < NCH; c++) begin
      v = int'(load_val[c*CW +: CW]);
      if (stop[c]) begin
        run[c] = 0; rem[c] = 0;
      end else if (load[c]) begin
        if (v != 0) begin rem[c] = v; rel[c] = v; per[c] = mode[c]; run[c] = 1; end
        else begin run[c] = 0; rem[c] = 0; evq.push_back('{c, e, 0}); end
      end else if (run[c] && t_seen && !pause[c]) begin
        rem[c] = rem[c] - 1;
        if (rem[c] == 0) begin
          if (per[c]) rem[c] = rel[c]; else run[c] = 0;
          evq.push_back('{c, e, rem[c]});
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin @(posedge CLOCK_50); if (KEY) model_step(); end
  end
  initial forever begin @(negedge KEY); model_reset(); end

  // ---------------- checking ----------------
  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d, t=%0t)", nm, act, exp, e, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++; n_err++;
    $display("FAIL %s: timed out (t=%0t)", nm, $time);
  endtask

  // monitor: pops the queued done event for the current edge
  initial forever begin
    @(negedge CLOCK_50);
    if (KEY) begin
      check("mon_base_tick", int'(base_tick), int'(tick_now));
      for (int c = 0; c < NCH; c++) begin
        int hit;
        hit = -1;
        for (int i = 0; i < evq.size(); i++) if (evq[i].ch == c && evq[i].e == e) hit = i;
        check($sformatf("mon_busy%0d", c), int'(busy[c]), int'(run[c]));
        check($sformatf("mon_count%0d", c), int'(count[c*CW +: CW]), rem[c]);
        check($sformatf("mon_done%0d", c), int'(done[c]), int'(hit >= 0));
        if (hit >= 0) begin
          check($sformatf("mon_done_count%0d", c), int'(count[c*CW +: CW]), evq[hit].cnt);
          evq.delete(hit);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLOCK_50); #1; cyc++;
  endtask

  task automatic wait_bt(input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin tick(); if (base_tick) begin at = cyc; break; end end
    if (at < 0) fail("wait_base_tick");
  endtask

  task automatic wait_done(input int ch, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin tick(); if (done[ch]) begin at = cyc; break; end end
    if (at < 0) fail($sformatf("wait_done%0d", ch));
  endtask

  task automatic start(input int ch, input int v, input bit m);
    sync_clr = 1; tick(); sync_clr = 0;
    load[ch] = 1; load_val[ch*CW +: CW] = CW'(v); mode[ch] = m; tick(); load[ch] = 0;
  endtask

  initial begin
    int t1, t2, tl, td, td2, td3, pulses;
    bit found;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("rst_base_tick", int'(base_tick), 0);
    check("rst_count", int'(count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    KEY = 1;

    // prescaler period and width
    wait_bt(3*DIV, t1);
    tick(); check("bt_width", int'(base_tick), 0);
    wait_bt(3*DIV, t2);
    check("bt_period", t2 - t1, DIV);

    // one-shot ch0, V=3
    start(0, 3, 0); tl = cyc;
    check("os_load_count", int'(count[CW-1:0]), 3);
    check("os_load_busy", int'(busy[0]), 1);
    wait_done(0, 5*DIV, td);
    check("os_latency", td - tl, 3*DIV);
    check("os_end_count", int'(count[CW-1:0]), 0);
    pulses = 0;
    for (int k = 0; k < 15; k++) begin tick(); pulses += int'(done[0]); end
    check("os_done_once", pulses, 0);
    check("os_busy_after", int'(busy[0]), 0);

    // periodic ch1, V=2, then lose one tick to pause
    start(1, 2, 1); tl = cyc;
    wait_done(1, 4*DIV, td);
    check("per_first", td - tl, 2*DIV);
    check("per_reload_count", int'(count[2*CW-1:CW]), 2);
    wait_done(1, 4*DIV, td2);
    check("per_period", td2 - td, 2*DIV);
    pause[1] = 1; repeat (DIV) tick(); pause[1] = 0;
    wait_done(1, 5*DIV, td3);
    check("pause_slip", td3 - td2, 3*DIV);
    stop[1] = 1; tick(); stop[1] = 0;
    check("stop_busy", int'(busy[1]), 0);
    check("stop_count", int'(count[2*CW-1:CW]), 0);
    check("stop_no_done", int'(done[1]), 0);

    // load on the expiring tick wins
    start(0, 2, 0);
    found = 0;
    for (int k = 0; k < 4*DIV; k++) begin
      tick();
      if (count[CW-1:0] == CW'(1) && base_tick) begin found = 1; break; end
    end
    if (!found) fail("prio_setup");
    else begin
      load[0] = 1; load_val[CW-1:0] = 5; tick(); load[0] = 0;
      check("prio_no_done", int'(done[0]), 0);
      check("prio_count", int'(count[CW-1:0]), 5);
      check("prio_busy", int'(busy[0]), 1);
    end
    repeat (3) tick();
    stop[0] = 1; load[0] = 1; load_val[CW-1:0] = 7; tick(); stop[0] = 0; load[0] = 0;
    check("stop_load_busy", int'(busy[0]), 0);
    check("stop_load_count", int'(count[CW-1:0]), 0);
    check("stop_load_done", int'(done[0]), 0);

    // zero load: immediate expiry
    load[0] = 1; load_val[CW-1:0] = 0; tick(); load[0] = 0;
    check("zero_done", int'(done[0]), 1);
    check("zero_busy", int'(busy[0]), 0);
    tick();
    check("zero_done_1cyc", int'(done[0]), 0);

    // random traffic, checked by the monitor
    for (int k = 0; k < 500; k++) begin
      sync_clr = ($urandom_range(0, 39) == 0);
      for (int c = 0; c < NCH; c++) begin
        stop[c]  = ($urandom_range(0, 59) == 0);
        load[c]  = ($urandom_range(0, 14) == 0);
        load_val[c*CW +: CW] = CW'($urandom_range(0, 4));
        mode[c]  = 1'($urandom_range(0, 1));
        pause[c] = ($urandom_range(0, 7) == 0);
      end
      tick();
    end
    sync_clr = 0; stop = '0; load = '0; pause = '0;
    repeat (5*DIV) tick();

    // asynchronous reset mid-run at count 4
    start(0, 6, 0);
    found = 0;
    for (int k = 0; k < 5*DIV; k++) begin tick(); if (count[CW-1:0] == CW'(4)) begin found = 1; break; end end
    if (!found) fail("arst_setup");
    #2; KEY = 0; #1;
    check("arst_count", int'(count[CW-1:0]), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_pre", int'(u_dut.pre), 0);
    check("arst_base_tick", int'(base_tick), 0);
    repeat (2) @(posedge CLOCK_50);
    #1; KEY = 1;
    repeat (3*DIV) tick();
    check("evq_drained", evq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tick_timer_bank.md
# tick_timer_bank

Parametrised timebase and countdown-timer bank for the game logic. A free-running prescaler divides CLOCK_50 down to a base tick of TICK_HZ. NCH independent channels count that tick down from a loaded value in one-shot or periodic mode, each raising a done pulse at expiry. It supersedes the single fixed one-second enable generator and drives frame timers, ball-roll delays and on-screen countdowns.

## Interface
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 1, base tick rate in Hz. DIV = CLK_HZ/TICK_HZ must be an integer ≥ 2; elaboration error otherwise.
- NCH, 2, number of timer channels (1..8).
- CW, 8, per-channel count width in bits.

Ports:
- CLOCK_50  in  1  system clock; every register is on its rising edge.
- KEY  in  1  asynchronous active-low reset.
- sync_clr  in  1  synchronous prescaler restart; active high.
- stop  in  NCH  per-channel abort; active high.
- load  in  NCH  per-channel load/start strobe; active high.
- load_val  in  NCH*CW  per-channel start value; channel i uses bits [i*CW +: CW].
- mode  in  NCH  per-channel mode, sampled at load: 0 = one-shot, 1 = periodic.
- pause  in  NCH  per-channel hold; active high.
- base_tick  out  1  one-cycle pulse once per DIV cycles.
- count  out  NCH*CW  current remaining count per channel.
- busy  out  NCH  channel is in RUN.
- done  out  NCH  one-cycle expiry pulse per channel.

## Operation
- Prescaler: counter of width $clog2(DIV).
  - Counts 0..DIV-1, then wraps to 0.
  - base_tick is registered: high for exactly one cycle, in the cycle after the prescaler holds DIV-1. Period is exactly DIV cycles.
  - sync_clr forces the prescaler to 0 and suppresses the base_tick that would otherwise issue next cycle.
  - The next base_tick then appears DIV cycles after the sync_clr cycle.
- Each channel has a two-state FSM (IDLE, RUN) plus registers count[CW], reload[CW] and mode_r.
- Per-channel priority, highest first: stop > load > base_tick decrement.
- stop: state goes to IDLE and count to 0. No done pulse. reload is unchanged.
- load with load_val ≠ 0:
  - count and reload take load_val; mode_r takes mode.
  - State goes to RUN, from IDLE or from RUN (restart).
- load with load_val = 0: state goes to IDLE, count to 0, and done pulses once (immediate expiry).
- Decrement: in RUN, with pause low and base_tick high, no stop and no load:
  - count > 1: count decrements by 1.
  - count = 1, mode_r = 0: count goes to 0, state to IDLE, done pulses.
  - count = 1, mode_r = 1: count reloads from reload, state stays RUN, done pulses.
- pause high: the decrement is skipped for that tick. The tick is lost, not deferred. load and stop still act.
- A base_tick arriving in IDLE has no effect.
- No arithmetic wraps: count never decrements below 0.
- busy = (state == RUN). done is registered and never held longer than one cycle.

## Timing
- Reset (KEY low, asynchronous): prescaler 0, base_tick 0, and for every channel count 0, reload 0, mode_r 0, IDLE, busy 0, done 0.
- KEY deassertion is synchronised by the system. The first base_tick follows DIV cycles after the first active edge.
- load sampled at edge N: count and busy are updated at edge N.
- First decrement: on the first base_tick high strictly after the load cycle, so the first period can be partial. Assert sync_clr together with load to get full periods.
- Expiry: done is high in the cycle after the base_tick that takes count from 1.
  - In that same cycle count shows 0 (one-shot) or the reload value (periodic).
- From a load of V at the cycle after a sync_clr-aligned restart, done occurs V*DIV cycles later.
- load in the same cycle as the expiring tick: load wins, no done, count = load_val.
- stop and load in the same cycle: stop wins.
- Channels are fully independent. Simultaneous done on several channels is legal.

## Test plan
- Reset/prescaler (CLK_HZ=10, TICK_HZ=1 → DIV=10): hold KEY low, then release → all outputs 0. base_tick pulses every 10 cycles, each pulse exactly 1 cycle wide.
- One-shot (ch0): sync_clr and load with load_val=3, mode=0 → count steps 3,2,1,0 on successive ticks. done pulses once, 30 cycles after the load. busy then falls and stays 0.
- Periodic with pause (ch1): load_val=2, mode=1 → done every 20 cycles and count cycles 2,1,2. Hold pause across one tick → that decrement is skipped and the next done slips by 10 cycles.
- Priority: ch0 running at count=1, assert load (load_val=5) on the tick cycle → no done, count=5. On a later cycle assert stop and load together → IDLE, count=0, no done.
- Zero load and reset mid-run: load_val=0 → done the next cycle, busy stays 0. With ch0 at count=4, pull KEY low asynchronously between edges → count 0, busy 0 and prescaler 0 immediately.
